nonoverlap_clkgen: RTL and testbench

//  Two-phase non-overlapping clock generator that drives the CLK pins of latch

---
 rtl/nonoverlap_clkgen.sv | 142 ++++++++++++++
 tb/tb_nonoverlap_clkgen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nonoverlap_clkgen.sv
// nonoverlap_clkgen
//   Two-phase non-overlapping clock generator for latch-based pipelines.
//   It derives PHI1 and PHI2 from the master clock. Each phase stays high for
//   max(DIV,1) cycles, and a max(GAP,1)-cycle dead time separates the phases.
//   DIV and GAP are captured at the start of every period.
// Ports
//   CLK      master clock, rising-edge active
//   RST      asynchronous, active-high reset
//   EN       run request, sampled in IDLE and in the last cycle of G21
//   DIV      phase high time in CLK cycles (0 treated as 1)
//   GAP      dead time between phases in CLK cycles (0 treated as 1)
//   PHI1     phase-1 latch enable, taken straight from a state flop
//   PHI2     phase-2 latch enable, taken straight from a state flop
//   ACTIVE   high whenever the generator is not idle
//   CYC_CNT  completed PHI1+PHI2 periods, wrapping
module nonoverlap_clkgen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic [DIV_W-1:0] GAP,
    output logic             PHI1,
    output logic             PHI2,
    output logic             ACTIVE,
    output logic [CNT_W-1:0] CYC_CNT
);

    // The encoding puts PHI1, PHI2 and ACTIVE on dedicated state bits.
    // Each output is therefore a bare flop output and cannot glitch.
    //   bit0 = PHI1, bit1 = PHI2, bit3 = ACTIVE
    typedef enum logic [3:0] {
        StIdle = 4'b0000,
        StP1   = 4'b1001,
        StG12  = 4'b1000,
        StP2   = 4'b1010,
        StG21  = 4'b1100
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [DIV_W-1:0]   div_eff;
    logic [DIV_W-1:0]   gap_eff;

    assign div_eff = (DIV == '0) ? DIV_W'(1) : DIV;
    assign gap_eff = (GAP == '0) ? DIV_W'(1) : GAP;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= DIV_W'(1);
            gap_q   <= DIV_W'(1);
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        gap_d   = gap_q;
        cyc_d   = cyc_q;
        case (state_q)
            StIdle: begin
                if (EN) begin
                    state_d = StP1;
                    div_d   = div_eff;
                    gap_d   = gap_eff;
                    cnt_d   = div_eff - DIV_W'(1);
                end
            end
            StP1: begin
                if (cnt_q == '0) begin
                    state_d = StG12;
                    cnt_d   = gap_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StG12: begin
                if (cnt_q == '0) begin
                    state_d = StP2;
                    cnt_d   = div_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StP2: begin
                if (cnt_q == '0) begin
                    state_d = StG21;
                    cnt_d   = gap_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StG21: begin
                if (cnt_q == '0) begin
                    // EN is only looked at here, so a started period always completes.
                    cyc_d = cyc_q + CNT_W'(1);
                    if (EN) begin
                        state_d = StP1;
                        div_d   = div_eff;
                        gap_d   = gap_eff;
                        cnt_d   = div_eff - DIV_W'(1);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: plain wires from the state and count flops
    always_comb begin
        PHI1    = state_q[0];
        PHI2    = state_q[1];
        ACTIVE  = state_q[3];
        CYC_CNT = cyc_q;
    end

endmodule

// File: tb/tb_nonoverlap_clkgen.sv
// tb_nonoverlap_clkgen
//   Directed and random stimulus. The reference model tracks only the position
//   within a period and the captured DIV and GAP values.
module tb_nonoverlap_clkgen;

    localparam int unsigned DIV_W = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN  = 1'b0;
    logic [DIV_W-1:0] DIV = '0;
    logic [DIV_W-1:0] GAP = '0;
    logic             phi1, phi2, active;
    logic [15:0]      cyc_cnt;
    logic             phi1_b, phi2_b, active_b;
    logic [1:0]       cyc_cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    bit          m_active;
    int unsigned m_pos, m_d, m_g, m_cnt;

    always #5 CLK = ~CLK;

    nonoverlap_clkgen #(.DIV_W(DIV_W), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .GAP(GAP),
        .PHI1(phi1), .PHI2(phi2), .ACTIVE(active), .CYC_CNT(cyc_cnt)
    );

    nonoverlap_clkgen #(.DIV_W(DIV_W), .CNT_W(2)) u_dut_w2 (
        .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .GAP(GAP),
        .PHI1(phi1_b), .PHI2(phi2_b), .ACTIVE(active_b), .CYC_CNT(cyc_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned eff(input logic [DIV_W-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_cnt    = 0;
    endtask

    // One rising edge of the reference timeline
    task automatic model_edge();
        if (!m_active) begin
            if (EN) begin
                m_active = 1;
                m_pos    = 0;
                m_d      = eff(DIV);
                m_g      = eff(GAP);
            end
        end else if (m_pos == 2 * (m_d + m_g) - 1) begin
            m_cnt++;
            if (EN) begin
                m_pos = 0;
                m_d   = eff(DIV);
                m_g   = eff(GAP);
            end else begin
                m_active = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare_all();
        logic e1, e2;
        e1 = m_active && (m_pos < m_d);
        e2 = m_active && (m_pos >= m_d + m_g) && (m_pos < 2 * m_d + m_g);
        check_eq("phi1", 32'(phi1), 32'(e1));
        check_eq("phi2", 32'(phi2), 32'(e2));
        check_eq("active", 32'(active), 32'(m_active));
        check_eq("cyc_cnt", 32'(cyc_cnt), m_cnt & 32'hFFFF);
        check_eq("phi1_w2", 32'(phi1_b), 32'(e1));
        check_eq("phi2_w2", 32'(phi2_b), 32'(e2));
        check_eq("cyc_cnt_w2", 32'(cyc_cnt_b), m_cnt & 32'h3);
        check_eq("no_overlap", 32'(phi1 & phi2), 32'd0);
    endtask

    // Advance one clock, update the model, check, return at the falling edge
    task automatic step();
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    // RST is raised away from any rising edge, so the outputs must drop
    // asynchronously
    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        m_d = 1;
        m_g = 1;
        @(negedge CLK);
        do_reset();

        // Idle with EN low
        repeat (10) step();

        // DIV=3 GAP=1: period of 8 cycles
        DIV = 3; GAP = 1; EN = 1;
        repeat (9) step();
        check_eq("t2_cyc_after_period", 32'(cyc_cnt), 32'd1);
        repeat (16) step();

        // DIV=0 GAP=0 behave as 1/1
        do_reset();
        DIV = 0; GAP = 0; EN = 1;
        repeat (13) step();

        // DIV changed to 1 while in P2 only affects the next period
        do_reset();
        DIV = 4; GAP = 2; EN = 1;
        repeat (8) step();        // entry + 7: inside P2
        DIV = 1;
        repeat (5) step();        // period ends, next P1 begins
        check_eq("t4_next_p1_on", 32'(phi1), 32'd1);
        step();
        check_eq("t4_next_p1_width1", 32'(phi1), 32'd0);
        repeat (6) step();

        // EN dropped in the second P1 cycle: the period completes, then idle
        do_reset();
        DIV = 4; GAP = 2; EN = 1;
        step();                   // enter P1
        step();                   // second P1 cycle
        EN = 0;
        repeat (11) step();
        check_eq("t5_idle_after_12", 32'(active), 32'd0);
        check_eq("t5_cyc_one", 32'(cyc_cnt), 32'd1);
        repeat (4) step();

        // Async reset in the middle of P1
        DIV = 4; GAP = 2; EN = 1;
        step();
        step();
        #2;
        RST = 1'b1;
        #1;
        check_eq("t6_async_phi1", 32'(phi1), 32'd0);
        check_eq("t6_async_cyc", 32'(cyc_cnt), 32'd0);
        @(negedge CLK);
        do_reset();

        // 2-bit period counter wraps 1,2,3,0
        DIV = 0; GAP = 0; EN = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            repeat (4) step();
            check_eq("t6_cnt2_wrap", 32'(cyc_cnt_b), 32'(k % 4));
        end

        // Random traffic: EN, DIV and GAP change at arbitrary times
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) EN = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 4) == 0) DIV = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) GAP = DIV_W'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
